tpu_job_seq: RTL and testbench
==============================

Name: tpu_job_seq

Overview:
- Job sequencer in front of the tpuv1 matrix-multiply block; sole owner of its r_w/addr/dataIn/dataOut bus.
- Accepts one job command, then streams A rows, B rows and optional C preload words into tpuv1.
- Issues the start write, waits out the compute window, then streams the 16 C half-row words back out through a valid/ready port.
- Sits between the host/DMA word stream and tpuv1.

Parameters:
- DIM, 8, matrix dimension; the 0x100/0x200/0x300 address map below is fixed for DIM=8.
- DATAW, 64, bus word width.
- ADDRW, 16, tpuv1 address width.
- COMPUTE_CYCLES, 3*DIM-1, idle cycles after the start write before C may be accessed.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- job_valid  in  1  job command offered
- job_acc  in  1  1 = preload C from stream; 0 = clear C to zero
- job_ready  out  1  sequencer idle, command accepted on job_valid&job_ready
- in_valid  in  1  input word valid
- in_data  in  DATAW  input word (A rows, B rows, C half-rows, in that order)
- in_ready  out  1  input word consumed this cycle
- out_valid  out  1  C word available
- out_data  out  DATAW  C half-row word
- out_ready  in  1  downstream accepts C word
- tpu_r_w  out  1  to tpuv1 r_w (1 = write)
- tpu_addr  out  ADDRW  to tpuv1 addr
- tpu_dataIn  out  DATAW  to tpuv1 dataIn
- tpu_dataOut  in  DATAW  from tpuv1 dataOut
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when the last C word is accepted

Behaviour:
- Reset: state IDLE, idx=0, out_valid=0, out_data=0, done=0. Bus outputs are combinational from state: idle bus = r_w 0, addr 0x0000, dataIn 0.
- Idle bus is driven in IDLE, WAIT, DRAIN, and in any load cycle without a transfer. The address must never be 0x0400 except in START.
- IDLE:
  - job_ready=1.
  - On job_valid, latch job_acc, idx=0, go to LOAD_A.
- LOAD_A:
  - in_ready=1.
  - On in_valid: r_w=1, addr=0x100+8*idx, dataIn=in_data, idx++.
  - After idx 7: idx=0, go to LOAD_B.
- LOAD_B:
  - Same as LOAD_A with addr=0x200+8*idx.
  - Words are written strictly in row order 0..7; each write shifts memB.
  - Then go to LOAD_C.
- LOAD_C, 16 words, idx 0..15, addr=0x300+8*idx (row=idx[3:1], high half=idx[0]):
  - acc=1: in_ready=1; write in_data on in_valid.
  - acc=0: in_ready=0; write dataIn=0 every cycle, 16 consecutive cycles, no stream dependence.
  - Then go to START.
- START:
  - Exactly one cycle with r_w=1, addr=0x0400, dataIn=0.
  - Then go to WAIT with wait counter=0.
- WAIT:
  - Idle bus for COMPUTE_CYCLES cycles (23 for DIM=8).
  - Then idx=0, go to READ_C.
- READ_C:
  - Drive r_w=0, addr=0x300+8*idx every cycle.
  - When (!out_valid || out_ready): out_data<=tpu_dataOut, out_valid<=1, idx++.
  - The read is combinational: sample on the edge ending the cycle the address is driven.
  - When out_valid && out_ready and no new capture: out_valid<=0.
  - After capturing idx 15, go to DRAIN.
- DRAIN:
  - Idle bus; on out_ready, out_valid<=0, done=1 for one cycle, go to IDLE.
- Backpressure:
  - A stalled input (in_valid=0) holds the state and idx and drives the idle bus.
  - out_ready=0 holds out_data stable and idx frozen.
- job_valid outside IDLE is ignored, with job_ready=0.
- tpu_dataOut is ignored outside READ_C.
- Reset asserted mid-job returns to IDLE immediately. tpuv1 is reset by the same rst_n.
- Throughput: a job with no stalls takes 8+8+16+1+23+16 cycles plus 1 drain cycle from acceptance to done.

Test Plan:
- Identity A, B=all 2, acc=0, continuous streams, out_ready=1 -> 16 output words. Row r, half h, element j = 2 (C=A·B). done pulses once, 73 cycles after job acceptance. Address 0x0400 appears on exactly one cycle.
- A=B=all 1, acc=1, C preload all 5 -> every C element 13. Output words arrive in order addr 0x300..0x378.
- in_valid toggling every other cycle during LOAD_A/LOAD_B -> identical results to scenario 1. tpu_r_w is high only on cycles with in_valid.
- out_ready held 0 for 10 cycles after the first capture -> out_data constant, tpu_addr stays 0x308. No word is lost or duplicated; 16 words total.
- Reset pulse during WAIT -> state IDLE, out_valid=0, busy=0, job_ready=1. A fresh job afterwards completes correctly.
- job_valid held high through a whole job -> a second job is accepted only in the cycle after done. Back-to-back results are correct with a stale-C clear (acc=0).

Source files
------------

// File: rtl/tpu_job_seq.sv
// tpu_job_seq: job sequencer that loads A/B/C into tpuv1, starts it, waits out compute and streams C back out.
module tpu_job_seq #(
  parameter int DIM            = 8,
  parameter int DATAW          = 64,
  parameter int ADDRW          = 16,
  parameter int COMPUTE_CYCLES = 3*DIM-1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  input  logic             job_acc,
  output logic             job_ready,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_dataIn,
  input  logic [DATAW-1:0] tpu_dataOut,
  output logic             busy,
  output logic             done
);
  localparam int IW = $clog2(2*DIM);
  localparam int CW = $clog2(COMPUTE_CYCLES+1);
  localparam logic [IW-1:0] LAST_AB = IW'(DIM-1);
  localparam logic [IW-1:0] LAST_C  = IW'(2*DIM-1);
  localparam logic [CW-1:0] LAST_W  = CW'(COMPUTE_CYCLES-1);
  localparam logic [ADDRW-1:0] A_BASE  = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] B_BASE  = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] C_BASE  = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] GO_ADDR = ADDRW'(16'h0400);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_C, S_START, S_WAIT, S_READ_C, S_DRAIN} state_t;

  state_t           r_state, w_state;
  logic [IW-1:0]    r_idx, w_idx;
  logic [CW-1:0]    r_wcnt, w_wcnt;
  logic             r_acc, w_acc, r_out_valid, w_out_valid;
  logic [DATAW-1:0] r_out_data, w_out_data;
  logic [ADDRW-1:0] w_off;

  assign w_off     = ADDRW'({r_idx, 3'b000});
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_state != S_IDLE;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_wcnt      <= '0;
      r_acc       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_wcnt      <= w_wcnt;
      r_acc       <= w_acc;
      r_out_valid <= w_out_valid;
      r_out_data  <= w_out_data;
    end

  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_wcnt      = r_wcnt;
    w_acc       = r_acc;
    w_out_valid = r_out_valid;
    w_out_data  = r_out_data;
    job_ready   = 1'b0;
    in_ready    = 1'b0;
    done        = 1'b0;
    tpu_r_w     = 1'b0;
    tpu_addr    = '0;
    tpu_dataIn  = '0;
    case (r_state)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          w_acc   = job_acc;
          w_idx   = '0;
          w_state = S_LOAD_A;
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tpu_r_w    = 1'b1;
          tpu_addr   = ((r_state == S_LOAD_A) ? A_BASE : B_BASE) + w_off;
          tpu_dataIn = in_data;
          w_idx      = (r_idx == LAST_AB) ? '0 : r_idx + 1'b1;
          w_state    = (r_idx != LAST_AB) ? r_state : (r_state == S_LOAD_A) ? S_LOAD_B : S_LOAD_C;
        end
      end
      S_LOAD_C: begin
        // without preload, C is cleared with one zero write per cycle regardless of the stream
        in_ready = r_acc;
        if (!r_acc || in_valid) begin
          tpu_r_w    = 1'b1;
          tpu_addr   = C_BASE + w_off;
          tpu_dataIn = r_acc ? in_data : '0;
          w_idx      = (r_idx == LAST_C) ? '0 : r_idx + 1'b1;
          w_state    = (r_idx == LAST_C) ? S_START : S_LOAD_C;
        end
      end
      S_START: begin
        tpu_r_w  = 1'b1;
        tpu_addr = GO_ADDR;
        w_wcnt   = '0;
        w_state  = S_WAIT;
      end
      S_WAIT: begin
        w_wcnt = r_wcnt + 1'b1;
        if (r_wcnt == LAST_W) begin
          w_idx   = '0;
          w_state = S_READ_C;
        end
      end
      S_READ_C: begin
        // tpuv1 read data is combinational, so capture at the end of the address cycle
        tpu_addr = C_BASE + w_off;
        if (!r_out_valid || out_ready) begin
          w_out_data  = tpu_dataOut;
          w_out_valid = 1'b1;
          w_idx       = (r_idx == LAST_C) ? '0 : r_idx + 1'b1;
          w_state     = (r_idx == LAST_C) ? S_DRAIN : S_READ_C;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          w_out_valid = 1'b0;
          done        = 1'b1;
          w_state     = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_tpu_job_seq.sv
// tb_tpu_job_seq: randomized job-level bench for tpu_job_seq against a behavioural tpuv1 and matrix-product reference.
module tb_tpu_job_seq;
  localparam int COMP = 23;
  typedef logic [63:0] rows8_t [8];
  typedef logic [63:0] rows16_t [16];

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        job_valid = 1'b0, job_acc = 1'b0, job_ready;
  logic        in_valid = 1'b0, in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [63:0] out_data;
  logic        tpu_r_w, busy, done;
  logic [15:0] tpu_addr;
  logic [63:0] tpu_dataIn, tpu_dataOut;

  int errs = 0, checks = 0, cyc = 0, last_done = -100;
  int n_start = 0, n_rw_bad = 0, n_bad = 0, n_jr_busy = 0;
  logic [15:0] rd_q[$];
  rows8_t  sa, sb, mA, mB;
  rows16_t sc, mC;
  int tcnt;
  bit started;

  tpu_job_seq dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_acc(job_acc), .job_ready(job_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_dataIn(tpu_dataIn), .tpu_dataOut(tpu_dataOut),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // C word w = row w/2, columns 4*(w%2)..+3 as 16-bit lanes; A/B rows are 8 byte elements
  function automatic logic [63:0] cword(input rows8_t a, input rows8_t b, input logic [63:0] cp, input int w);
    logic [63:0] r;
    logic [15:0] s;
    int col;
    r = cp;
    for (int j = 0; j < 4; j++) begin
      col = 4*(w%2) + j;
      s = cp[16*j +: 16];
      for (int k = 0; k < 8; k++) s = s + 16'(a[w/2][8*k +: 8]) * 16'(b[k][8*col +: 8]);
      r[16*j +: 16] = s;
    end
    return r;
  endfunction

  function automatic bit valid_waddr(input logic [15:0] a);
    int lim;
    lim = (a[15:8] == 8'h03) ? 16 : 8;
    return a == 16'h0400 || (a[15:8] >= 8'h01 && a[15:8] <= 8'h03 && a[2:0] == 3'd0 && int'(a[7:3]) < lim);
  endfunction

  // behavioural tpuv1: memories by address, product available COMP cycles after the start write
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin mA[i] <= '0; mB[i] <= '0; end
      for (int i = 0; i < 16; i++) mC[i] <= '0;
      tcnt <= 0;
      started <= 1'b0;
    end else begin
      tcnt <= tcnt + 1;
      if (tpu_r_w)
        case (tpu_addr[15:8])
          8'h01: mA[tpu_addr[5:3]] <= tpu_dataIn;
          8'h02: mB[tpu_addr[5:3]] <= tpu_dataIn;
          8'h03: mC[tpu_addr[6:3]] <= tpu_dataIn;
          8'h04: begin
            started <= 1'b1;
            tcnt <= 0;
            for (int w = 0; w < 16; w++) mC[w] <= cword(mA, mB, mC[w], w);
          end
          default: ;
        endcase
    end
  assign tpu_dataOut = (started && tcnt >= COMP && !tpu_r_w && tpu_addr[15:8] == 8'h03) ? mC[tpu_addr[6:3]] : 64'hDEAD_BEEF_0BAD_F00D;

  always @(negedge clk)
    if (rst_n) begin
      if (tpu_addr == 16'h0400) n_start++;
      if (tpu_r_w && tpu_addr >= 16'h0100 && tpu_addr < 16'h0300 && !in_valid) n_rw_bad++;
      if (tpu_r_w && !valid_waddr(tpu_addr)) n_bad++;
      if (!tpu_r_w && ((tpu_addr != 16'h0 && tpu_addr[15:8] != 8'h03) || tpu_dataIn != 64'h0)) n_bad++;
      if (busy && job_ready) n_jr_busy++;
      if (!tpu_r_w && tpu_addr[15:8] == 8'h03 && (rd_q.size() == 0 || rd_q[$] != tpu_addr)) rd_q.push_back(tpu_addr);
    end

  task automatic fill_random(input bit acc);
    for (int r = 0; r < 8; r++) begin sa[r] = {$urandom, $urandom}; sb[r] = {$urandom, $urandom}; end
    for (int w = 0; w < 16; w++) sc[w] = acc ? {$urandom, $urandom} : 64'h0;
  endtask

  task automatic accept_job(input bit acc, output int acyc);
    int g = 0;
    job_valid = 1'b1;
    job_acc = acc;
    while (g < 500) begin
      @(negedge clk);
      if (job_ready) break;
      @(posedge clk); #1;
      g++;
    end
    acyc = cyc;
    checks++;
    if (g >= 500) begin errs++; $display("FAIL accept: job_ready never seen within %0d cycles", g); end
    @(posedge clk); #1;
  endtask

  task automatic drive_stream(input bit acc, input int mode);
    logic [63:0] wq[$];
    int i = 0, g = 0;
    for (int r = 0; r < 8; r++) wq.push_back(sa[r]);
    for (int r = 0; r < 8; r++) wq.push_back(sb[r]);
    if (acc) for (int w = 0; w < 16; w++) wq.push_back(sc[w]);
    while (i < wq.size() && g < 3000) begin
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ~g[0] : 1'($urandom_range(0, 1));
      in_data = wq[i];
      @(negedge clk);
      if (in_valid && in_ready) i++;
      @(posedge clk); #1;
      g++;
    end
    in_valid = 1'b0;
    in_data = '0;
    checks++;
    if (i != wq.size()) begin errs++; $display("FAIL stream: consumed %0d words, required %0d", i, wq.size()); end
  endtask

  task automatic run_job(input string nm, input bit acc, input int mode, input bit stall, input bit hold, input bit imm, input int lat);
    logic [63:0] got[$];
    logic [63:0] d0 = '0, ex;
    int acyc, dcyc = -1, st = 0, g = 0;
    int s0 = n_start, rb0 = n_rw_bad, b0 = n_bad, j0 = n_jr_busy, q0 = rd_q.size();
    accept_job(acc, acyc);
    if (!hold) job_valid = 1'b0;
    if (imm) begin
      checks++;
      if (acyc != last_done + 1) begin errs++; $display("FAIL %s accept_cycle: got %0d required %0d", nm, acyc, last_done + 1); end
    end
    drive_stream(acc, mode);
    while (g < 1000) begin
      out_ready = stall ? (st >= 10) : 1'b1;
      @(negedge clk);
      if (stall && out_valid && st < 10) begin
        if (st == 0) d0 = out_data;
        checks++;
        if (out_data !== d0 || tpu_addr !== 16'h0308) begin
          errs++; $display("FAIL %s stall%0d: data %h addr %h, required %h addr 0308", nm, st, out_data, tpu_addr, d0);
        end
        st++;
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (done) begin dcyc = cyc; break; end
      @(posedge clk); #1;
      g++;
    end
    last_done = dcyc;
    checks++;
    if (dcyc < 0) begin errs++; $display("FAIL %s done: no done pulse within %0d cycles", nm, g); end
    checks++;
    if (got.size() != 16) begin errs++; $display("FAIL %s word_count: got %0d required 16", nm, got.size()); end
    for (int w = 0; w < 16 && w < got.size(); w++) begin
      ex = cword(sa, sb, acc ? sc[w] : 64'h0, w);
      checks++;
      if (got[w] !== ex) begin errs++; $display("FAIL %s word%0d: got %h required %h", nm, w, got[w], ex); end
    end
    checks++;
    if (n_start - s0 != 1) begin errs++; $display("FAIL %s start_cycles: got %0d required 1", nm, n_start - s0); end
    checks++;
    if (n_rw_bad != rb0 || n_bad != b0 || n_jr_busy != j0) begin
      errs++; $display("FAIL %s bus: rw_without_valid %0d bad_bus %0d ready_while_busy %0d, required 0 0 0", nm, n_rw_bad - rb0, n_bad - b0, n_jr_busy - j0);
    end
    checks++;
    if (rd_q.size() - q0 != 16) begin errs++; $display("FAIL %s read_addrs: got %0d distinct required 16", nm, rd_q.size() - q0); end
    else for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_q[q0+i] !== 16'(16'h0300 + 8*i)) begin errs++; $display("FAIL %s read_addr%0d: got %h required %h", nm, i, rd_q[q0+i], 16'h0300 + 8*i); end
    end
    if (lat > 0) begin
      checks++;
      if (dcyc - acyc != lat) begin errs++; $display("FAIL %s latency: got %0d required %0d", nm, dcyc - acyc, lat); end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({job_ready, busy, out_valid, done, tpu_r_w, in_ready} !== 6'b100000) begin
      errs++; $display("FAIL reset_ctrl: ready/busy/ov/done/rw/in_ready=%b required 100000", {job_ready, busy, out_valid, done, tpu_r_w, in_ready});
    end
    checks++;
    if (out_data !== 64'h0) begin errs++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    checks++;
    if (tpu_addr !== 16'h0 || tpu_dataIn !== 64'h0) begin errs++; $display("FAIL reset_bus: addr %h dataIn %h required 0 0", tpu_addr, tpu_dataIn); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_identity;
    for (int r = 0; r < 8; r++) begin sa[r] = 64'h1 << (8*r); sb[r] = 64'h0202_0202_0202_0202; end
    for (int w = 0; w < 16; w++) sc[w] = 64'h0;
    run_job("identity", 1'b0, 0, 1'b0, 1'b0, 1'b0, 73);
  endtask

  task automatic test_preload;
    for (int r = 0; r < 8; r++) begin sa[r] = 64'h0101_0101_0101_0101; sb[r] = sa[r]; end
    for (int w = 0; w < 16; w++) sc[w] = 64'h0005_0005_0005_0005;
    run_job("preload", 1'b1, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_toggle;
    for (int r = 0; r < 8; r++) begin sa[r] = 64'h1 << (8*r); sb[r] = 64'h0202_0202_0202_0202; end
    for (int w = 0; w < 16; w++) sc[w] = 64'h0;
    run_job("toggle", 1'b0, 1, 1'b0, 1'b0, 1'b0, 0);
    fill_random(1'b1);
    run_job("random_gaps", 1'b1, 2, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_out_stall;
    fill_random(1'b1);
    run_job("out_stall", 1'b1, 0, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid;
    int s0 = n_start, g = 0, acyc;
    fill_random(1'b0);
    accept_job(1'b0, acyc);
    job_valid = 1'b0;
    drive_stream(1'b0, 0);
    while (n_start == s0 && g < 200) begin @(posedge clk); #1; g++; end
    checks++;
    if (g >= 200) begin errs++; $display("FAIL reset_mid_start: start write not seen in %0d cycles", g); end
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, job_ready, out_valid, tpu_r_w} !== 4'b0100 || tpu_addr !== 16'h0) begin
      errs++; $display("FAIL reset_mid: busy/ready/ov/rw=%b addr %h required 0100 addr 0000", {busy, job_ready, out_valid, tpu_r_w}, tpu_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill_random(1'b1);
    run_job("after_reset", 1'b1, 2, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    fill_random(1'b1);
    run_job("b2b_first", 1'b1, 0, 1'b0, 1'b1, 1'b0, 0);
    fill_random(1'b0);
    run_job("b2b_second", 1'b0, 0, 1'b0, 1'b0, 1'b1, 73);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_identity;
    test_preload;
    test_toggle;
    test_out_stall;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
